// File: rtl/sc2bin_fc_mc.sv
// Multi-channel, multi-lane stochastic-to-binary converter: saturating signed accumulation
// of differential streams, then ReLU and clipped left shift, delivered over valid/ready.
module sc2bin_fc_mc #(
  parameter int unsigned NUM_CH       = 4,
  parameter int unsigned LANES        = 2,
  parameter int unsigned BITWIDTH_INT = 10,
  parameter int unsigned BITWIDTH_OUT = 8,
  parameter int unsigned MAX_SHFT     = 4,
  parameter int unsigned LEN_W        = 10
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             start,
  input  logic [LEN_W-1:0]                 stream_len,
  input  logic [$clog2(MAX_SHFT+1)-1:0]    shft_amt,
  input  logic                             sc_valid,
  input  logic [NUM_CH*LANES-1:0]          sc_pos,
  input  logic [NUM_CH*LANES-1:0]          sc_neg,
  output logic                             busy,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [NUM_CH*BITWIDTH_OUT-1:0]   bin_out,
  output logic [NUM_CH-1:0]                sat_flag
);

  localparam int unsigned ShW = $clog2(MAX_SHFT + 1);
  localparam int unsigned SW  = BITWIDTH_INT + MAX_SHFT;
  localparam int          AccMax = (1 << (BITWIDTH_INT - 1)) - 1;
  localparam int          AccMin = -(1 << (BITWIDTH_INT - 1));
  localparam logic [ShW-1:0] MaxShft = ShW'(MAX_SHFT);
  localparam logic [SW-1:0]  OutMax  = SW'((1 << BITWIDTH_OUT) - 1);

  typedef enum logic [1:0] {StIdle, StAccum, StAct, StOut} state_e;

  state_e                           state_q, state_d;
  logic [LEN_W-1:0]                 len_q, len_d;
  logic [ShW-1:0]                   shft_q, shft_d;
  logic [LEN_W-1:0]                 cnt_q, cnt_d;
  logic signed [BITWIDTH_INT-1:0]   acc_q [NUM_CH];
  logic signed [BITWIDTH_INT-1:0]   acc_d [NUM_CH];
  logic [NUM_CH-1:0]                sticky_q, sticky_d;
  logic [NUM_CH*BITWIDTH_OUT-1:0]   bin_q, bin_d;
  logic [NUM_CH-1:0]                sat_q, sat_d;

  logic signed [BITWIDTH_INT-1:0]   acc_nxt [NUM_CH];
  logic [BITWIDTH_OUT-1:0]          res [NUM_CH];
  logic [NUM_CH-1:0]                acc_clip, res_clip;
  int                               delta, sum;
  logic [SW-1:0]                    relu, shifted;

  // Per-channel arithmetic: next saturated accumulator value and the activated output.
  always_comb begin
    delta    = 0;
    sum      = 0;
    relu     = '0;
    shifted  = '0;
    acc_clip = '0;
    res_clip = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      delta = 0;
      for (int l = 0; l < LANES; l++) begin
        delta = delta + int'(sc_pos[c*LANES+l]) - int'(sc_neg[c*LANES+l]);
      end
      sum = int'(acc_q[c]) + delta;
      if (sum > AccMax) begin
        acc_nxt[c]  = BITWIDTH_INT'(AccMax);
        acc_clip[c] = 1'b1;
      end else if (sum < AccMin) begin
        acc_nxt[c]  = BITWIDTH_INT'(AccMin);
        acc_clip[c] = 1'b1;
      end else begin
        acc_nxt[c] = BITWIDTH_INT'(sum);
      end
      relu        = acc_q[c][BITWIDTH_INT-1] ? '0 : {{MAX_SHFT{1'b0}}, acc_q[c]};
      shifted     = relu << shft_q;
      res_clip[c] = shifted > OutMax;
      res[c]      = res_clip[c] ? '1 : shifted[BITWIDTH_OUT-1:0];
    end
  end

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    shft_d   = shft_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    sticky_d = sticky_q;
    bin_d    = bin_q;
    sat_d    = sat_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          len_d    = stream_len;
          shft_d   = (shft_amt > MaxShft) ? MaxShft : shft_amt;
          cnt_d    = '0;
          sticky_d = '0;
          for (int c = 0; c < NUM_CH; c++) acc_d[c] = '0;
          state_d  = (stream_len == '0) ? StAct : StAccum;
        end
      end
      StAccum: begin
        if (sc_valid) begin
          acc_d    = acc_nxt;
          sticky_d = sticky_q | acc_clip;
          cnt_d    = cnt_q + 1'b1;
          if (cnt_d == len_q) state_d = StAct;
        end
      end
      StAct: begin
        for (int c = 0; c < NUM_CH; c++) bin_d[c*BITWIDTH_OUT +: BITWIDTH_OUT] = res[c];
        sat_d    = sticky_q | res_clip;
        sticky_d = sticky_q | res_clip;
        state_d  = StOut;
      end
      StOut: begin
        if (out_ready) begin
          sticky_d = '0;
          sat_d    = '0;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      len_q    <= '0;
      shft_q   <= '0;
      cnt_q    <= '0;
      sticky_q <= '0;
      bin_q    <= '0;
      sat_q    <= '0;
      for (int c = 0; c < NUM_CH; c++) acc_q[c] <= '0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      shft_q   <= shft_d;
      cnt_q    <= cnt_d;
      sticky_q <= sticky_d;
      bin_q    <= bin_d;
      sat_q    <= sat_d;
      acc_q    <= acc_d;
    end
  end

  assign busy      = (state_q != StIdle);
  assign out_valid = (state_q == StOut);
  assign bin_out   = bin_q;
  assign sat_flag  = sat_q;

endmodule

// File: tb/tb_sc2bin_fc_mc.sv
// Self-checking bench for sc2bin_fc_mc: directed scenarios plus randomized conversions
// checked against a per-beat arithmetic reference model.
module tb_sc2bin_fc_mc;

  localparam int NUM_CH = 4;
  localparam int LANES  = 2;
  localparam int BWO    = 8;
  localparam int PW     = NUM_CH * LANES;
  localparam int ACCMAX = 511;
  localparam int ACCMIN = -512;
  localparam int OUTMAX = 255;
  localparam int SHMAX  = 4;

  logic                  clk = 1'b0;
  logic                  reset_n;
  logic                  start;
  logic [9:0]            stream_len;
  logic [2:0]            shft_amt;
  logic                  sc_valid;
  logic [PW-1:0]         sc_pos, sc_neg;
  logic                  busy, out_valid, out_ready;
  logic [NUM_CH*BWO-1:0] bin_out;
  logic [NUM_CH-1:0]     sat_flag;

  int n_checks = 0;
  int n_fail   = 0;
  logic [PW-1:0] fix_pos, fix_neg;

  sc2bin_fc_mc dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .stream_len (stream_len),
    .shft_amt   (shft_amt),
    .sc_valid   (sc_valid),
    .sc_pos     (sc_pos),
    .sc_neg     (sc_neg),
    .busy       (busy),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .bin_out    (bin_out),
    .sat_flag   (sat_flag)
  );

  always #5 clk = ~clk;

  function automatic int delta_of(input logic [PW-1:0] p, input logic [PW-1:0] n, input int c);
    int d = 0;
    for (int l = 0; l < LANES; l++) begin
      if (p[c*LANES+l]) d++;
      if (n[c*LANES+l]) d--;
    end
    return d;
  endfunction

  // vmode: 0 always valid, 1 toggling starting high, 2 random. pmode: 0 fixed pattern, 1 random.
  task automatic convert(input string name, input int len, input int shft, input int vmode,
                         input int pmode, input int hold, input int exp_edges);
    int acc [NUM_CH];
    bit sat [NUM_CH];
    int beats = 0, edges = 0, early = 0, bad = 0, tog = 0, guard, sh, eff;
    logic v;
    logic [PW-1:0] p, n;
    logic [NUM_CH*BWO-1:0] exp_bin;
    logic [NUM_CH-1:0] exp_sat;
    for (int c = 0; c < NUM_CH; c++) begin
      acc[c] = 0;
      sat[c] = 1'b0;
    end
    guard      = 8 * len + 50;
    start      = 1'b1;
    stream_len = 10'(len);
    shft_amt   = 3'(shft);
    sc_valid   = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    edges = 1;
    while (beats < len && edges < guard) begin
      if (out_valid !== 1'b0 || busy !== 1'b1) early++;
      v = (vmode == 0) ? 1'b1 : (vmode == 1) ? (tog % 2 == 0) : 1'($urandom_range(0, 1));
      tog++;
      p = pmode ? PW'($urandom) : fix_pos;
      n = pmode ? PW'($urandom) : fix_neg;
      sc_valid = v;
      sc_pos   = p;
      sc_neg   = n;
      if (v) begin
        for (int c = 0; c < NUM_CH; c++) begin
          acc[c] += delta_of(p, n, c);
          if (acc[c] > ACCMAX) begin acc[c] = ACCMAX; sat[c] = 1'b1; end
          if (acc[c] < ACCMIN) begin acc[c] = ACCMIN; sat[c] = 1'b1; end
        end
        beats++;
      end
      @(posedge clk); #1;
      edges++;
    end
    n_checks++;
    if (beats < len) begin
      n_fail++;
      $display("FAIL %s timeout: beats %0d required %0d", name, beats, len);
    end
    // ACT cycle: extra beats offered here must be ignored.
    if (out_valid !== 1'b0 || busy !== 1'b1) early++;
    sc_valid = 1'b1;
    sc_pos   = PW'($urandom);
    sc_neg   = PW'($urandom);
    @(posedge clk); #1;
    edges++;
    sc_valid = 1'b0;
    eff = (shft > SHMAX) ? SHMAX : shft;
    for (int c = 0; c < NUM_CH; c++) begin
      sh = (acc[c] < 0 ? 0 : acc[c]) << eff;
      if (sh > OUTMAX) begin sh = OUTMAX; sat[c] = 1'b1; end
      exp_bin[c*BWO +: BWO] = BWO'(sh);
      exp_sat[c]            = sat[c];
    end
    n_checks++;
    if (early !== 0) begin
      n_fail++;
      $display("FAIL %s early_out_valid: got %0d bad cycles required 0", name, early);
    end
    n_checks++;
    if (out_valid !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL %s out_valid: got valid=%b busy=%b required 1 1", name, out_valid, busy);
    end
    n_checks++;
    if (bin_out !== exp_bin) begin
      n_fail++;
      $display("FAIL %s bin_out: got %h required %h", name, bin_out, exp_bin);
    end
    n_checks++;
    if (sat_flag !== exp_sat) begin
      n_fail++;
      $display("FAIL %s sat_flag: got %b required %b", name, sat_flag, exp_sat);
    end
    if (exp_edges > 0) begin
      n_checks++;
      if (edges !== exp_edges) begin
        n_fail++;
        $display("FAIL %s latency: got %0d edges required %0d", name, edges, exp_edges);
      end
    end
    for (int i = 0; i < hold; i++) begin
      out_ready = 1'b0;
      start     = (i % 2 == 0);
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || busy !== 1'b1 || bin_out !== exp_bin || sat_flag !== exp_sat)
        bad++;
    end
    if (hold > 0) begin
      n_checks++;
      if (bad !== 0) begin
        n_fail++;
        $display("FAIL %s hold_stable: got %0d bad cycles required 0", name, bad);
      end
    end
    // Handshake with start also high: start must be ignored here.
    out_ready  = 1'b1;
    start      = 1'b1;
    stream_len = 10'd0;
    @(posedge clk); #1;
    out_ready = 1'b0;
    start     = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || sat_flag !== '0 || bin_out !== exp_bin) begin
      n_fail++;
      $display("FAIL %s handshake: got valid=%b busy=%b sat=%b bin=%h required 0 0 0 %h",
               name, out_valid, busy, sat_flag, bin_out, exp_bin);
    end
  endtask

  task automatic test_reset();
    reset_n    = 1'b0;
    start      = 1'b0;
    stream_len = '0;
    shft_amt   = '0;
    sc_valid   = 1'b0;
    sc_pos     = '0;
    sc_neg     = '0;
    out_ready  = 1'b0;
    #3;
    n_checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || bin_out !== '0 || sat_flag !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got busy=%b valid=%b bin=%h sat=%b required all 0",
               busy, out_valid, bin_out, sat_flag);
    end
    #14 reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    fix_pos = 8'b0000_0011;
    fix_neg = 8'b0000_0000;
    convert("basic", 8, 0, 0, 0, 0, 10);
  endtask

  task automatic test_negative();
    fix_pos = 8'b1000_0000;
    fix_neg = 8'b0100_1100;
    convert("negative", 8, 0, 0, 0, 0, 10);
  endtask

  task automatic test_shift_clip();
    fix_pos = 8'b0011_0000;
    fix_neg = 8'b0000_0000;
    convert("shift3", 20, 3, 0, 0, 0, 22);
    convert("shift7", 20, 7, 0, 0, 0, 22);
    convert("shift1", 20, 1, 0, 0, 0, 22);
  endtask

  task automatic test_acc_sat();
    fix_pos = 8'b0000_0011;
    fix_neg = 8'b0000_1100;
    convert("acc_sat", 600, 0, 0, 0, 0, 602);
  endtask

  task automatic test_reset_mid();
    start      = 1'b1;
    stream_len = 10'd50;
    shft_amt   = 3'd0;
    sc_valid   = 1'b1;
    sc_pos     = '1;
    sc_neg     = '0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || bin_out !== '0 || sat_flag !== '0) begin
      n_fail++;
      $display("FAIL reset_mid: got busy=%b valid=%b bin=%h sat=%b required all 0",
               busy, out_valid, bin_out, sat_flag);
    end
    sc_valid = 1'b0;
    sc_pos   = '0;
    #4 reset_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_idle: got busy=%b required 0", busy);
    end
    convert("len_zero", 0, 0, 0, 0, 0, 2);
  endtask

  task automatic test_flow();
    fix_pos = 8'b0001_0011;
    fix_neg = 8'b1000_0000;
    convert("flow", 4, 1, 1, 0, 5, 0);
  endtask

  task automatic test_random();
    int len;
    for (int i = 0; i < 8; i++) begin
      len = (i == 7) ? int'($urandom_range(280, 320)) : int'($urandom_range(0, 40));
      convert("random", len, int'($urandom_range(0, 7)), 2, 1, int'($urandom_range(0, 3)), 0);
    end
  endtask

  task automatic test_back_to_back();
    fix_pos = 8'b1100_0011;
    fix_neg = 8'b0000_0001;
    convert("b2b_a", 12, 2, 0, 0, 0, 14);
    fix_pos = 8'b0000_1100;
    fix_neg = 8'b0011_0000;
    convert("b2b_b", 6, 4, 0, 0, 0, 8);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_negative();
    test_shift_clip();
    test_acc_sat();
    test_reset_mid();
    test_flow();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
